uart_rx_oversampled: RTL and testbench

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_oversampled_if.sv | 28 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_oversampled.sv | 118 +++++++++++
 tb/tb_uart_rx_oversampled.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parity mode constants
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// rtl/uart_rx_oversampled_if.sv - serial line and received-frame signal bundle
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
) (
  input logic clk
);

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 parity_err;

  // master drives the line, slave is the receiver
  modport master (
    input  clk,
    output rx,
    input  data, data_valid, rx_busy, frame_err, parity_err
  );

  modport slave (
    input  clk,
    input  rx,
    output data, data_valid, rx_busy, frame_err, parity_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchronizer with falling-edge detect, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rx_s    = s2_q;
  assign rx_fall = s3_q & ~s2_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampling UART receiver with parity and stop-bit checking
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_INV   = (PARITY == PARITY_ODD);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 stop_bad_q, par_bad_q, done_q;
  logic                 frame_end;
  logic                 rx_s, rx_fall;
  logic                 bit_tick, mid_tick;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign bit_tick = (cnt_q == CNT_LAST);
  assign mid_tick = (cnt_q == CNT_MID);

  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (rx_fall) state_d = ST_START;
      ST_START:  if (mid_tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_tick && bit_idx_q == BIT_LAST)
                   state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_tick && bit_idx_q == STOP_LAST) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      stop_bad_q <= 1'b0;
      par_bad_q  <= 1'b0;
      done_q     <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= frame_end;

      // counter restarts on every state change and at each bit boundary
      if (state_d != state_q || state_q == ST_IDLE || bit_tick)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);

      if (state_d != state_q)
        bit_idx_q <= '0;
      else if (bit_tick && (state_q == ST_DATA || state_q == ST_STOP))
        bit_idx_q <= bit_idx_q + BW'(1);

      if (state_q == ST_START) begin
        stop_bad_q <= 1'b0;
        par_bad_q  <= 1'b0;
      end
      if (state_q == ST_DATA && bit_tick)
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      if (state_q == ST_PARITY && bit_tick)
        par_bad_q <= rx_s ^ (^shift_q) ^ ODD_INV;
      if (state_q == ST_STOP && bit_tick && !rx_s)
        stop_bad_q <= 1'b1;

      rx_busy <= (state_d == ST_DATA) || (state_d == ST_PARITY) || (state_d == ST_STOP);

      // single outcome per frame: frame error masks parity error masks data
      data_valid <= done_q & ~stop_bad_q & ~par_bad_q;
      frame_err  <= done_q & stop_bad_q;
      parity_err <= done_q & ~stop_bad_q & par_bad_q;
      if (done_q && !stop_bad_q && !par_bad_q)
        data <= shift_q;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed bench for 8N1, 8E1 and 7N2 receiver builds
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_oversampled_if #(.DATA_BITS(8)) ifa (.clk(clk));
  uart_rx_oversampled_if #(.DATA_BITS(8)) ifp (.clk(clk));
  uart_rx_oversampled_if #(.DATA_BITS(7)) ifs (.clk(clk));

  uart_rx_oversampled #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(ifa.rx), .data(ifa.data), .data_valid(ifa.data_valid),
    .rx_busy(ifa.rx_busy), .frame_err(ifa.frame_err), .parity_err(ifa.parity_err));
  uart_rx_oversampled #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(ifp.rx), .data(ifp.data), .data_valid(ifp.data_valid),
    .rx_busy(ifp.rx_busy), .frame_err(ifp.frame_err), .parity_err(ifp.parity_err));
  uart_rx_oversampled #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(PARITY_NONE), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .rx(ifs.rx), .data(ifs.data), .data_valid(ifs.data_valid),
    .rx_busy(ifs.rx_busy), .frame_err(ifs.frame_err), .parity_err(ifs.parity_err));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int dv_n[3], fe_n[3], pe_n[3], br_n[3], dv_t[3], br_t[3];
  int s_dv[3], s_fe[3], s_pe[3], s_br[3];
  logic busy_p[3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] last_d[3], prev_d[3];

  task automatic note(input int i, input logic dv, input logic busy, input logic fe,
                      input logic pe, input logic [8:0] d);
    if (dv === 1'b1) begin
      dv_n[i]++;
      dv_t[i] = cyc;
      prev_d[i] = last_d[i];
      last_d[i] = d;
    end
    if (fe === 1'b1) fe_n[i]++;
    if (pe === 1'b1) pe_n[i]++;
    if (busy === 1'b1 && busy_p[i] !== 1'b1) begin
      br_n[i]++;
      br_t[i] = cyc;
    end
    busy_p[i] = busy;
  endtask

  always @(negedge clk) begin
    note(0, ifa.data_valid, ifa.rx_busy, ifa.frame_err, ifa.parity_err, 9'(ifa.data));
    note(1, ifp.data_valid, ifp.rx_busy, ifp.frame_err, ifp.parity_err, 9'(ifp.data));
    note(2, ifs.data_valid, ifs.rx_busy, ifs.frame_err, ifs.parity_err, 9'(ifs.data));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      s_dv[i] = dv_n[i];
      s_fe[i] = fe_n[i];
      s_pe[i] = pe_n[i];
      s_br[i] = br_n[i];
    end
  endtask

  task automatic set_rx(input int i, input logic v);
    case (i)
      0:       ifa.rx = v;
      1:       ifp.rx = v;
      default: ifs.rx = v;
    endcase
  endtask

  // par < 0 means no parity bit; line is left at the last stop-bit level
  task automatic send(input int i, input logic [8:0] payload, input int nbits,
                      input int par, input int nstop, input logic stop_v);
    logic [15:0] fr;
    int n;
    fr = '1;
    n = 0;
    fr[n] = 1'b0;
    n++;
    for (int b = 0; b < nbits; b++) begin
      fr[n] = payload[b];
      n++;
    end
    if (par >= 0) begin
      fr[n] = par[0];
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      fr[n] = stop_v;
      n++;
    end
    for (int b = 0; b < n; b++) begin
      set_rx(i, fr[b]);
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin
    ifa.rx = 1'b1;
    ifp.rx = 1'b1;
    ifs.rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(ifa.data), 32'h0);
    check("rst_flags", {ifa.data_valid, ifa.rx_busy, ifa.frame_err, ifa.parity_err}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(ifa.rx_busy), 32'h0);

    snap();
    send(0, 9'h0A5, 8, -1, 1, 1'b1);
    repeat (16) @(negedge clk);
    check("a5_dv_cnt", dv_n[0] - s_dv[0], 1);
    check("a5_data", 32'(ifa.data), 32'hA5);
    check("a5_err_cnt", (fe_n[0] - s_fe[0]) + (pe_n[0] - s_pe[0]), 0);
    check("a5_busy_rise", br_n[0] - s_br[0], 1);
    check("a5_latency", dv_t[0] - br_t[0], 145);

    snap();
    set_rx(0, 1'b0);
    repeat (4) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (40) @(negedge clk);
    check("glitch_busy_rise", br_n[0] - s_br[0], 0);
    check("glitch_pulses", (dv_n[0] - s_dv[0]) + (fe_n[0] - s_fe[0]) + (pe_n[0] - s_pe[0]), 0);
    check("glitch_data", 32'(ifa.data), 32'hA5);

    snap();
    send(0, 9'h055, 8, -1, 1, 1'b0);
    repeat (400) @(negedge clk);
    check("ferr_cnt", fe_n[0] - s_fe[0], 1);
    check("ferr_dv_cnt", dv_n[0] - s_dv[0], 0);
    check("ferr_pe_cnt", pe_n[0] - s_pe[0], 0);
    check("ferr_frames", br_n[0] - s_br[0], 1);
    check("ferr_data", 32'(ifa.data), 32'hA5);
    check("ferr_busy", 32'(ifa.rx_busy), 32'h0);
    set_rx(0, 1'b1);
    repeat (32) @(negedge clk);
    snap();
    send(0, 9'h05A, 8, -1, 1, 1'b1);
    repeat (16) @(negedge clk);
    check("recover_dv_cnt", dv_n[0] - s_dv[0], 1);
    check("recover_data", 32'(ifa.data), 32'h5A);

    snap();
    send(1, 9'h0A5, 8, 0, 1, 1'b1);
    repeat (16) @(negedge clk);
    check("par_good_dv", dv_n[1] - s_dv[1], 1);
    check("par_good_pe", pe_n[1] - s_pe[1], 0);
    check("par_good_data", 32'(ifp.data), 32'hA5);
    snap();
    send(1, 9'h03C, 8, 1, 1, 1'b1);
    repeat (16) @(negedge clk);
    check("par_bad_pe", pe_n[1] - s_pe[1], 1);
    check("par_bad_dv", dv_n[1] - s_dv[1], 0);
    check("par_bad_fe", fe_n[1] - s_fe[1], 0);
    check("par_bad_data", 32'(ifp.data), 32'hA5);

    snap();
    send(2, 9'h041, 7, -1, 2, 1'b1);
    send(2, 9'h07F, 7, -1, 2, 1'b1);
    repeat (16) @(negedge clk);
    check("b2b_dv_cnt", dv_n[2] - s_dv[2], 2);
    check("b2b_first", 32'(prev_d[2]), 32'h41);
    check("b2b_second", 32'(last_d[2]), 32'h7F);
    check("b2b_errs", (fe_n[2] - s_fe[2]) + (pe_n[2] - s_pe[2]), 0);

    // 0xFF keeps the line high after the abort so no false start follows
    snap();
    set_rx(0, 1'b0);
    repeat (16) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (56) @(negedge clk);
    check("mid_busy", 32'(ifa.rx_busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_data", 32'(ifa.data), 32'h0);
    check("abort_flags", {ifa.data_valid, ifa.rx_busy, ifa.frame_err, ifa.parity_err}, 32'h0);
    repeat (250) @(negedge clk);
    check("abort_pulses", (dv_n[0] - s_dv[0]) + (fe_n[0] - s_fe[0]) + (pe_n[0] - s_pe[0]), 0);
    snap();
    send(0, 9'h012, 8, -1, 1, 1'b1);
    repeat (16) @(negedge clk);
    check("post_rst_dv", dv_n[0] - s_dv[0], 1);
    check("post_rst_data", 32'(ifa.data), 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
